// File: rtl/fetch_ctrl_if.sv
// Bus between the fetch sequencer and its surroundings: the PC, the
// instruction ROM, the decode/ALU stage and the user-input synchroniser.
interface fetch_ctrl_if #(
  parameter int AddrSz  = 6,
  parameter int InstrSz = 24
);
  logic [AddrSz-1:0]  pc_addr;
  logic [AddrSz-1:0]  imem_addr;
  logic [InstrSz-1:0] imem_data;
  logic               alu_zero;
  logic               in_valid;
  logic               in_ack;
  logic               rel_branch;
  logic [AddrSz-1:0]  offset;
  logic               halt;
  logic [InstrSz-1:0] instr;
  logic               instr_valid;

  // Sequencer side
  modport master (
    input  pc_addr, imem_data, alu_zero, in_valid,
    output imem_addr, in_ack, rel_branch, offset, halt, instr, instr_valid
  );

  // Environment side (PC, ROM, datapath, input synchroniser)
  modport slave (
    output pc_addr, imem_data, alu_zero, in_valid,
    input  imem_addr, in_ack, rel_branch, offset, halt, instr, instr_valid
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Multicycle fetch/control sequencer. Issues one instruction every two
// cycles (FETCH, EXEC), resolves relative branches against the ALU zero
// flag, and handles WAIT (released by one user-input press) and STOP.
module fetch_ctrl #(
  parameter int AddrSz  = 6,
  parameter int InstrSz = 24
) (
  input  logic          clk,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_WAIT = 4'hD;
  localparam logic [3:0] OP_STOP = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WAIT  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [InstrSz-1:0] ir_q;
  logic               armed_q;
  logic [3:0]         opcode;
  logic               release_wait;

  // The ROM is addressed straight from the PC; data returns one cycle later.
  assign bus.imem_addr = bus.pc_addr;

  assign opcode       = bus.imem_data[InstrSz-1 -: 4];
  assign release_wait = (state_q == S_WAIT) && bus.in_valid && armed_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Keep the last executed instruction so instr has a stable value outside EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
    end else if (state_q == S_EXEC) begin
      ir_q <= bus.imem_data;
    end
  end

  // One press releases one WAIT: disarm on release, re-arm whenever the strobe is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b1;
    end else if (release_wait) begin
      armed_q <= 1'b0;
    end else if (!bus.in_valid) begin
      armed_q <= 1'b1;
    end
  end

  // Next-state and output decode; the PC is held unless something below lets it move.
  always_comb begin
    state_d         = state_q;
    bus.halt        = 1'b1;
    bus.rel_branch  = 1'b0;
    bus.offset      = '0;
    bus.in_ack      = 1'b0;
    bus.instr       = ir_q;
    bus.instr_valid = 1'b0;

    case (state_q)
      S_FETCH: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        bus.instr  = bus.imem_data;
        bus.offset = bus.imem_data[AddrSz-1:0];
        case (opcode)
          OP_WAIT: state_d = S_WAIT;
          OP_STOP: state_d = S_STOP;
          OP_BEQ: begin
            bus.halt       = 1'b0;
            bus.rel_branch = bus.alu_zero;
            state_d        = S_FETCH;
          end
          OP_BNE: begin
            bus.halt       = 1'b0;
            bus.rel_branch = !bus.alu_zero;
            state_d        = S_FETCH;
          end
          OP_B: begin
            bus.halt       = 1'b0;
            bus.rel_branch = 1'b1;
            state_d        = S_FETCH;
          end
          default: begin
            bus.halt        = 1'b0;
            bus.instr_valid = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end

      S_WAIT: begin
        if (release_wait) begin
          bus.in_ack = 1'b1;
          bus.halt   = 1'b0;
          state_d    = S_FETCH;
        end
      end

      S_STOP: begin
        state_d = S_STOP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: provides a PC and a synchronous ROM around the
// sequencer and checks it instruction by instruction against a model that
// tracks the expected PC, last instruction and press availability.
module tb_fetch_ctrl;

  localparam int AW = 6;
  localparam int IW = 24;

  logic clk;
  logic reset;
  logic [AW-1:0] pc;
  logic [IW-1:0] rom [64];

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  logic [AW-1:0] m_pc;
  logic [IW-1:0] m_ir;
  logic          m_armed;
  int            iv_mode;   // 0: in_valid low, 1: high, 2: random

  fetch_ctrl_if #(.AddrSz(AW), .InstrSz(IW)) bus ();

  fetch_ctrl #(.AddrSz(AW), .InstrSz(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else if (!bus.halt) pc <= bus.rel_branch ? pc + bus.offset : pc + 6'd1;
  end
  assign bus.pc_addr = pc;

  // Synchronous instruction ROM
  always_ff @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  task automatic chk(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
    vectors++;
    assert (obsv === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obsv, expv);
    end
  endtask

  task automatic pick_iv(output logic iv);
    case (iv_mode)
      0:       iv = 1'b0;
      1:       iv = 1'b1;
      default: iv = 1'($urandom_range(0, 1));
    endcase
    bus.in_valid = iv;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 24'h000000;
  endtask

  // Assert reset mid-cycle, check outputs, release at a falling edge.
  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_zero = 1'b0;
    #1;
    chk("rst_halt",  32'(bus.halt), 32'd1);
    chk("rst_rel",   32'(bus.rel_branch), 32'd0);
    chk("rst_off",   32'(bus.offset), 32'd0);
    chk("rst_ack",   32'(bus.in_ack), 32'd0);
    chk("rst_ivld",  32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    m_pc    = '0;
    m_ir    = '0;
    m_armed = 1'b1;
    chk("rst_pc", 32'(pc), 32'd0);
  endtask

  // One instruction: FETCH cycle then EXEC cycle. az_mode 0/1 fixed, 2 random.
  task automatic step(input int az_mode, output logic [3:0] op);
    logic [IW-1:0] w;
    logic az, iv, taken, dp, hold;
    pick_iv(iv);
    bus.alu_zero = 1'($urandom_range(0, 1));
    #1;
    chk("fetch_halt",  32'(bus.halt), 32'd1);
    chk("fetch_rel",   32'(bus.rel_branch), 32'd0);
    chk("fetch_off",   32'(bus.offset), 32'd0);
    chk("fetch_ack",   32'(bus.in_ack), 32'd0);
    chk("fetch_ivld",  32'(bus.instr_valid), 32'd0);
    chk("fetch_instr", 32'(bus.instr), 32'(m_ir));
    chk("fetch_pc",    32'(pc), 32'(m_pc));
    @(posedge clk); #1;
    if (!iv) m_armed = 1'b1;

    w  = rom[m_pc];
    op = w[IW-1 -: 4];
    az = (az_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(az_mode);
    bus.alu_zero = az;
    pick_iv(iv);
    #1;
    taken = (op == 4'hC) || (op == 4'hA && az) || (op == 4'hB && !az);
    hold  = (op == 4'hD) || (op == 4'hF);
    dp    = !((op == 4'hA) || (op == 4'hB) || (op == 4'hC) || hold);
    chk("exec_instr", 32'(bus.instr), 32'(w));
    chk("exec_off",   32'(bus.offset), 32'(w[AW-1:0]));
    chk("exec_rel",   32'(bus.rel_branch), 32'(taken));
    chk("exec_halt",  32'(bus.halt), 32'(hold));
    chk("exec_ivld",  32'(bus.instr_valid), 32'(dp));
    chk("exec_ack",   32'(bus.in_ack), 32'd0);
    @(posedge clk); #1;
    if (!iv) m_armed = 1'b1;
    m_ir = w;
    if (!hold) m_pc = taken ? m_pc + w[AW-1:0] : m_pc + 6'd1;
    chk("exec_pc_next", 32'(pc), 32'(m_pc));
  endtask

  // One cycle in WAIT with a given strobe level.
  task automatic wait_cycle(input logic iv, output logic released);
    bus.in_valid = iv;
    bus.alu_zero = 1'($urandom_range(0, 1));
    #1;
    released = m_armed && iv;
    chk("wait_ack",   32'(bus.in_ack), 32'(released));
    chk("wait_halt",  32'(bus.halt), 32'(!released));
    chk("wait_rel",   32'(bus.rel_branch), 32'd0);
    chk("wait_off",   32'(bus.offset), 32'd0);
    chk("wait_ivld",  32'(bus.instr_valid), 32'd0);
    chk("wait_instr", 32'(bus.instr), 32'(m_ir));
    @(posedge clk); #1;
    if (released) begin
      m_armed = 1'b0;
      m_pc    = m_pc + 6'd1;
    end else if (!iv) begin
      m_armed = 1'b1;
    end
    chk("wait_pc", 32'(pc), 32'(m_pc));
  endtask

  task automatic stop_cycle();
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.alu_zero = 1'($urandom_range(0, 1));
    #1;
    chk("stop_halt",  32'(bus.halt), 32'd1);
    chk("stop_ack",   32'(bus.in_ack), 32'd0);
    chk("stop_rel",   32'(bus.rel_branch), 32'd0);
    chk("stop_off",   32'(bus.offset), 32'd0);
    chk("stop_ivld",  32'(bus.instr_valid), 32'd0);
    chk("stop_instr", 32'(bus.instr), 32'(m_ir));
    @(posedge clk); #1;
    chk("stop_pc", 32'(pc), 32'(m_pc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] op;
    logic       rel_f;
    logic [3:0] opc;
    int         k;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_zero = 1'b0;
    iv_mode      = 0;
    m_pc = '0; m_ir = '0; m_armed = 1'b1;
    clear_rom();
    repeat (2) @(posedge clk);
    #1;

    // Datapath instruction at address 0
    rom[0] = 24'h012345;
    rom[1] = 24'h054321;
    do_reset();
    step(2, op);
    step(2, op);

    // BEQ -2 at address 5, taken then not taken
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {4'(i), 20'($urandom)};
    rom[5] = 24'hA0003E;
    do_reset();
    iv_mode = 2;
    for (int i = 0; i < 5; i++) step(2, op);
    step(1, op);
    chk("beq_taken_pc", 32'(pc), 32'd3);
    step(2, op);
    step(2, op);
    step(0, op);
    chk("beq_not_taken_pc", 32'(pc), 32'd6);

    // BNE both ways, unconditional branch wrapping below zero
    clear_rom();
    rom[0] = 24'hC0003F;
    rom[63] = 24'hB00002;
    rom[1] = 24'hB0003F;
    do_reset();
    step(2, op);
    chk("b_wrap_pc", 32'(pc), 32'd63);
    step(0, op);
    chk("bne_taken_pc", 32'(pc), 32'd1);
    step(1, op);
    chk("bne_not_taken_pc", 32'(pc), 32'd2);

    // WAIT handshake, held strobe, then STOP
    clear_rom();
    rom[2] = 24'hD00000;
    rom[3] = 24'hD00000;
    rom[4] = 24'hF00000;
    do_reset();
    iv_mode = 0;
    step(2, op);
    step(2, op);
    step(2, op);
    for (int i = 0; i < 5; i++) wait_cycle(1'b0, rel_f);
    wait_cycle(1'b1, rel_f);
    chk("wait1_pc", 32'(pc), 32'd3);
    iv_mode = 1;
    step(2, op);
    for (int i = 0; i < 3; i++) wait_cycle(1'b1, rel_f);
    chk("wait2_held_pc", 32'(pc), 32'd3);
    wait_cycle(1'b0, rel_f);
    wait_cycle(1'b1, rel_f);
    chk("wait2_pc", 32'(pc), 32'd4);
    iv_mode = 2;
    step(2, op);
    for (int i = 0; i < 8; i++) stop_cycle();
    do_reset();

    // Asynchronous reset in the middle of a WAIT cycle
    clear_rom();
    rom[0] = 24'hD00000;
    do_reset();
    iv_mode = 0;
    step(2, op);
    wait_cycle(1'b0, rel_f);
    wait_cycle(1'b0, rel_f);
    bus.in_valid = 1'b1;
    reset        = 1'b1;
    #1;
    chk("midwait_rst_ack",   32'(bus.in_ack), 32'd0);
    chk("midwait_rst_halt",  32'(bus.halt), 32'd1);
    chk("midwait_rst_instr", 32'(bus.instr), 32'd0);
    rom[0] = 24'h0ABCDE;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    m_pc = '0; m_ir = '0; m_armed = 1'b1;
    step(2, op);
    chk("after_rst_pc", 32'(pc), 32'd1);

    // Random programs
    for (int i = 0; i < 64; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        5:       opc = 4'hA;
        6:       opc = 4'hB;
        7:       opc = 4'hC;
        8:       opc = 4'hD;
        9:       opc = 4'hE;
        default: opc = 4'($urandom_range(0, 9));
      endcase
      rom[i] = {opc, 20'($urandom)};
    end
    do_reset();
    iv_mode = 2;
    for (int n = 0; n < 150; n++) begin
      step(2, op);
      if (op == 4'hD) begin
        rel_f = 1'b0;
        for (int c = 0; c < 100 && !rel_f; c++) wait_cycle(1'($urandom_range(0, 1)), rel_f);
        if (!rel_f) begin
          vectors++;
          miscompares++;
          $error("FAIL wait_bound: observed no release expected release within 100 cycles");
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
